// File: rtl/halt_mon_pkg.sv
// halt_mon_pkg: shared state encoding and halt-instruction constant for the halt monitor.
package halt_mon_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, ARMED = 2'd1, HALTED = 2'd2} halt_state_t;
  localparam logic [31:0] JAL_SELF_LOOP = 32'h0000006F;
endpackage

// File: rtl/rv32i_halt_monitor_sat_counter.sv
// sat_counter: up-counter with enable, synchronous clear and saturation at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk_i) cnt_q <= !resetn_i ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/rv32i_halt_monitor.sv
// rv32i_halt_monitor: flags end of program once the core spins on jal x0,0 for HALT_REPEAT valid fetches.
// Define HALT_MON_PC_CHECK_EN to also require the repeated fetches to share one PC.
module rv32i_halt_monitor
  import halt_mon_pkg::*;
#(
  parameter logic [31:0] HALT_INSN   = JAL_SELF_LOOP,
  parameter int          HALT_REPEAT = 5,
  parameter int          CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             inst_valid_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      pc_i,
  input  logic             clear_i,
  output logic             halted_o,
  output logic [31:0]      halt_pc_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [1:0]       state_o
);
  localparam logic [7:0] REP = 8'(HALT_REPEAT);
  halt_state_t state_q, state_d;
  logic [7:0]  mcnt_q, mcnt_d;
  logic [31:0] pc_q, pc_d;
  logic        halted_q, hit, pc_ok, live;
  assign hit  = inst_valid_i && inst_i == HALT_INSN;
  assign live = state_q != HALTED;
`ifdef HALT_MON_PC_CHECK_EN
  assign pc_ok = pc_i == pc_q;
`else
  assign pc_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    pc_d    = pc_q;
    if (clear_i) begin
      state_d = RUN;
      mcnt_d  = '0;
      pc_d    = '0;
    end else if (state_q == RUN && hit) begin
      mcnt_d  = 8'd1;
      pc_d    = pc_i;
      state_d = REP == 8'd1 ? HALTED : ARMED;
    end else if (state_q == ARMED && hit && pc_ok) begin
      mcnt_d  = mcnt_q + 8'd1;
      state_d = (mcnt_q + 8'd1 == REP) ? HALTED : ARMED;
    end else if (state_q == ARMED && hit) begin
      mcnt_d = 8'd1;
      pc_d   = pc_i;
    end else if (state_q == ARMED && inst_valid_i) begin
      mcnt_d  = '0;
      state_d = RUN;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q  <= RUN;
      mcnt_q   <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      pc_q     <= pc_d;
      halted_q <= state_d == HALTED;
    end
  end
  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (clear_i),
    .en_i     (live),
    .cnt_o    (cycle_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (clear_i),
    .en_i     (live && inst_valid_i),
    .cnt_o    (fetch_cnt_o)
  );
  assign halted_o  = halted_q;
  assign halt_pc_o = pc_q;
  assign state_o   = state_q;
endmodule
